screen_scanner: RTL and testbench
=================================

SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 Parameter GAP_CYCLES, default 2, number of cycles scr_read SHALL be held low after each accepted byte; legal values are 2 or more.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 frame_req  input  1  single-cycle pulse requesting one full-screen scan.
REQ-005 scr_read  output  1  screen byte read request to the CPU.
REQ-006 scr_read_idx  output  8  screen byte index 0..255 (32 lines x 8 bytes).
REQ-007 scr_read_byte  input  8  screen byte returned by the CPU, valid only with scr_read_ack.
REQ-008 scr_read_ack  input  1  one-cycle acknowledge from the CPU.
REQ-009 out_valid  output  1  out_byte/out_first/out_last hold a valid entry.
REQ-010 out_ready  input  1  downstream display driver accepts the entry.
REQ-011 out_byte  output  8  screen byte, MSB = leftmost pixel.
REQ-012 out_first  output  1  entry is index 0 of a frame.
REQ-013 out_last  output  1  entry is index 255 of a frame.
REQ-014 busy  output  1  scan in progress or FIFO not empty.

Function
REQ-015 States SHALL be IDLE, REQ, SETTLE and DRAIN; a 2-entry FIFO SHALL hold {byte, first, last}.
REQ-016 IDLE: on frame_req or pending set, idx SHALL be set to 0, pending cleared, and the next state SHALL be REQ.
REQ-017 REQ: scr_read SHALL be registered high, with scr_read_idx = idx held stable until an ack is sampled.
REQ-018 In REQ, the edge that samples scr_read_ack=1 SHALL push {scr_read_byte, idx==0, idx==255} into the FIFO, drive scr_read low from the next cycle, and enter SETTLE.
REQ-019 scr_read_ack SHALL be ignored, with no push, in IDLE, SETTLE and DRAIN.
REQ-020 SETTLE SHALL last exactly GAP_CYCLES cycles with scr_read low; this lets the CPU leave its idle state and fetch.
REQ-021 At the end of SETTLE: if idx==255, the next state SHALL be DRAIN; otherwise idx SHALL increment by 1.
REQ-022 After SETTLE (idx<255), the block SHALL enter REQ only when the FIFO is not full, and SHALL otherwise wait with scr_read low.
REQ-023 At most one read SHALL be outstanding, so a push SHALL never occur while the FIFO is full.
REQ-024 DRAIN SHALL wait until the FIFO is empty and then enter IDLE.
REQ-025 out_valid SHALL equal FIFO non-empty; the head SHALL be presented combinationally from the FIFO register.
REQ-026 An entry SHALL pop on a rising edge with out_valid && out_ready.
REQ-027 While out_valid && !out_ready, out_byte/out_first/out_last SHALL be held stable.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-029 frame_req outside IDLE SHALL set pending; multiple such requests SHALL collapse into one pending scan.
REQ-030 A frame_req in the same cycle IDLE consumes pending SHALL be absorbed, causing no extra scan.
REQ-031 busy SHALL be high when state != IDLE or the FIFO is non-empty.
REQ-032 Each scan SHALL produce exactly 256 entries, idx 0..255 in order, with no loss or duplication under any out_ready pattern.
REQ-033 idx SHALL not wrap within a scan; a new scan SHALL restart from 0.

Reset
REQ-034 While rst_n=0, and immediately on its assertion: state=IDLE, scr_read=0, scr_read_idx=0, FIFO empty, out_valid=0, out_byte=0, out_first=0, out_last=0, pending=0, busy=0.
REQ-035 Reset mid-scan SHALL discard the scan and all FIFO contents; no entry SHALL appear after release until a new frame_req.

Verification
REQ-036 Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 before the next clock edge.
REQ-037 Full frame: frame_req pulse, out_ready=1, model acks 2 cycles after each request with byte = idx XOR 8'hA5 -> 256 entries; entry 0 = 0xA5 with out_first=1; entry 255 = 0x5A with out_last=1; scr_read low at least 2 cycles between requests; busy returns to 0.
REQ-038 Backpressure: out_ready=0 from start -> after 2 pushes, scr_read stays low with no third request; raising out_ready -> scan resumes, bytes 0,1,2... in order, none lost or duplicated.
REQ-039 Spurious ack: scr_read_ack=1 with byte 0xFF during SETTLE and during IDLE -> FIFO count unchanged, no 0xFF entry emitted.
REQ-040 Pending collapse: three frame_req pulses during a scan -> exactly one further complete scan (512 entries total), then IDLE.
REQ-041 Reset mid-frame: rst_n low while idx=100 -> outputs cleared; after release, frame_req -> first request has scr_read_idx=0 and the first entry has out_first=1.

Source files
------------

// File: rtl/screen_scanner.sv
// Screen scanner: fetches the 256-byte screen from the CPU one byte at a time
// and streams it to the display driver through a 2-entry FIFO.
//
// state  | meaning
// IDLE   | no scan active; waits for frame_req or a pending request
// REQ    | scr_read held high at scr_read_idx until the CPU acknowledges
// SETTLE | scr_read low for GAP_CYCLES, then waits for FIFO room
// DRAIN  | last byte fetched; waits for the FIFO to empty
module screen_scanner #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  output logic       scr_read,
  output logic [7:0] scr_read_idx,
  input  logic [7:0] scr_read_byte,
  input  logic       scr_read_ack,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_first,
  output logic       out_last,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [7:0]    idx;
  logic          pending;
  logic [GW-1:0] gap_cnt;

  logic [9:0]    fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic          push;
  logic          pop;
  logic          fifo_full;

  assign push      = (state == REQ) && scr_read_ack;
  assign pop       = out_valid && out_ready;
  assign fifo_full = (count == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 8'd0;
      pending  <= 1'b0;
      gap_cnt  <= '0;
      scr_read <= 1'b0;
    end else begin
      if (frame_req && (state != IDLE))
        pending <= 1'b1;
      case (state)
        IDLE: begin
          // a frame_req arriving while pending is consumed folds into this scan
          if (frame_req || pending) begin
            idx      <= 8'd0;
            pending  <= 1'b0;
            state    <= REQ;
            scr_read <= 1'b1;
          end
        end
        REQ: begin
          if (scr_read_ack) begin
            state    <= SETTLE;
            scr_read <= 1'b0;
            gap_cnt  <= GAP_LOAD;
          end
        end
        SETTLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (idx == 8'd255) begin
            state <= DRAIN;
          end else if (!fifo_full) begin
            idx      <= idx + 8'd1;
            state    <= REQ;
            scr_read <= 1'b1;
          end
        end
        DRAIN: begin
          if (count == 2'd0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= 10'd0;
      fifo_mem[1] <= 10'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {scr_read_byte, (idx == 8'd0), (idx == 8'd255)};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign scr_read_idx = idx;
  assign out_valid    = (count != 2'd0);
  assign out_byte     = fifo_mem[rd_ptr][9:2];
  assign out_first    = fifo_mem[rd_ptr][1];
  assign out_last     = fifo_mem[rd_ptr][0];
  assign busy         = (state != IDLE) || (count != 2'd0);

endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner: CPU responder acks two cycles after each
// request with idx ^ 8'hA5; a monitor checks every popped entry against idx order.
module tb_screen_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_req;
  logic       scr_read;
  logic [7:0] scr_read_idx;
  logic [7:0] scr_read_byte;
  logic       scr_read_ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_first;
  logic       out_last;
  logic       busy;

  logic       cpu_ack = 1'b0;
  logic [7:0] cpu_byte = 8'd0;
  logic       spur_ack = 1'b0;
  int         wcnt = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor state
  logic [7:0] exp_idx = 8'd0;
  int         n_entries = 0;
  int         mon_err = 0;
  int         gap_err = 0;
  int         req_cnt = 0;
  int         low_run = 0;
  logic       have_req = 1'b0;
  logic       prev_sr = 1'b0;
  logic [7:0] e0_byte = 8'd0;
  logic       e0_first = 1'b0;
  logic [7:0] e255_byte = 8'd0;
  logic       e255_last = 1'b0;
  logic [7:0] last_byte = 8'd0;
  logic       last_first = 1'b0;

  assign scr_read_ack  = cpu_ack | spur_ack;
  assign scr_read_byte = spur_ack ? 8'hFF : cpu_byte;

  screen_scanner #(.GAP_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_req    (frame_req),
    .scr_read     (scr_read),
    .scr_read_idx (scr_read_idx),
    .scr_read_byte(scr_read_byte),
    .scr_read_ack (scr_read_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .out_first    (out_first),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // CPU responder
  always @(negedge clk) begin
    if (!rst_n || !scr_read || cpu_ack) begin
      cpu_ack = 1'b0;
      wcnt    = 0;
    end else begin
      wcnt = wcnt + 1;
      if (wcnt == 2) begin
        cpu_ack  = 1'b1;
        cpu_byte = scr_read_idx ^ 8'hA5;
      end
    end
  end

  // entry and request monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx  = 8'd0;
      have_req = 1'b0;
      low_run  = 0;
      prev_sr  = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_byte !== (exp_idx ^ 8'hA5) || out_first !== (exp_idx == 8'd0) ||
            out_last !== (exp_idx == 8'd255))
          mon_err = mon_err + 1;
        if (exp_idx == 8'd0) begin
          e0_byte  = out_byte;
          e0_first = out_first;
        end
        if (exp_idx == 8'd255) begin
          e255_byte = out_byte;
          e255_last = out_last;
        end
        last_byte  = out_byte;
        last_first = out_first;
        n_entries  = n_entries + 1;
        exp_idx    = exp_idx + 8'd1;
      end
      if (scr_read && !prev_sr) begin
        if (have_req && low_run < 2)
          gap_err = gap_err + 1;
        have_req = 1'b1;
        req_cnt  = req_cnt + 1;
        low_run  = 0;
      end
      if (!scr_read)
        low_run = low_run + 1;
      prev_sr = scr_read;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_frame_req();
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < bound) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check(tag, (quiet >= 4), 1);
  endtask

  task automatic wait_req(input string tag, input logic [7:0] idx, input int bound);
    int n = 0;
    @(negedge clk);
    while (!(scr_read && scr_read_idx == idx) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < bound), 1);
  endtask

  initial begin
    int base;
    int rbase;
    int n;

    rst_n     = 1'b0;
    frame_req = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scr_read", scr_read, 0);
    check("rst_idx", scr_read_idx, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full frame
    out_ready = 1'b1;
    base = n_entries;
    pulse_frame_req();
    check("busy_after_req", busy, 1);
    wait_idle("frame_timeout", 4000);
    check("frame_entries", n_entries - base, 256);
    check("frame_order", mon_err, 0);
    check("frame_gap", gap_err, 0);
    check("entry0_byte", e0_byte, 8'hA5);
    check("entry0_first", e0_first, 1);
    check("entry255_byte", e255_byte, 8'h5A);
    check("entry255_last", e255_last, 1);
    check("frame_busy_end", busy, 0);

    // spurious ack in IDLE
    base = n_entries;
    @(negedge clk) spur_ack = 1'b1;
    @(negedge clk) spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_spur_valid", out_valid, 0);
    check("idle_spur_entries", n_entries - base, 0);
    check("idle_spur_read", scr_read, 0);

    // backpressure, with a spurious ack during the first SETTLE
    out_ready = 1'b0;
    base  = n_entries;
    rbase = req_cnt;
    pulse_frame_req();
    n = 0;
    while (!scr_read && n < 50) begin @(negedge clk); n++; end
    while (scr_read && n < 50) begin @(negedge clk); n++; end
    check("bp_first_ack", (n < 50), 1);
    spur_ack = 1'b1;
    @(negedge clk) spur_ack = 1'b0;
    repeat (30) @(negedge clk);
    check("bp_req_count", req_cnt - rbase, 2);
    check("bp_read_low", scr_read, 0);
    check("bp_valid", out_valid, 1);
    check("bp_head_byte", out_byte, 8'hA5);
    check("bp_head_first", out_first, 1);
    repeat (7) @(negedge clk);
    check("bp_hold_byte", out_byte, 8'hA5);
    check("bp_hold_req", req_cnt - rbase, 2);
    out_ready = 1'b1;
    wait_idle("bp_timeout", 4000);
    check("bp_entries", n_entries - base, 256);
    check("bp_order", mon_err, 0);
    check("bp_gap", gap_err, 0);

    // pending collapse
    base = n_entries;
    pulse_frame_req();
    repeat (100) @(negedge clk);
    pulse_frame_req();
    repeat (5) @(negedge clk);
    pulse_frame_req();
    repeat (9) @(negedge clk);
    pulse_frame_req();
    wait_idle("pend_timeout", 8000);
    check("pend_entries", n_entries - base, 512);
    check("pend_order", mon_err, 0);
    repeat (50) @(negedge clk);
    check("pend_no_third", n_entries - base, 512);
    check("pend_read_low", scr_read, 0);
    check("pend_busy", busy, 0);

    // reset mid-frame
    pulse_frame_req();
    wait_req("mid_reach_100", 8'd100, 2000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_read", scr_read, 0);
    check("mid_rst_idx", scr_read_idx, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_byte", out_byte, 0);
    check("mid_rst_first", out_first, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_entries;
    repeat (20) @(negedge clk);
    check("post_rst_quiet", n_entries - base, 0);
    check("post_rst_read", scr_read, 0);
    pulse_frame_req();
    n = 0;
    while (!scr_read && n < 50) begin @(negedge clk); n++; end
    check("restart_req", scr_read, 1);
    check("restart_idx", scr_read_idx, 0);
    n = 0;
    while (n_entries == base && n < 50) begin @(negedge clk); n++; end
    check("restart_entry", (n_entries > base), 1);
    check("restart_first", last_first, 1);
    check("restart_byte", last_byte, 8'hA5);
    wait_idle("restart_timeout", 4000);
    check("restart_entries", n_entries - base, 256);
    check("restart_order", mon_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
